// File: rtl/pipelined_mac_param.sv
// Parametrised pipelined multiply-accumulate unit.
//
// Accepts one (a, b) pair per clock, tagged by in_valid. The product is
// formed one partial-product row per stage, then registered, and then
// folded into the accumulator. A pair sampled on edge k shows up with
// out_valid=1 after edge k+B_WIDTH+2, whatever the data and however
// many bubbles surround it.
//
// Parameters:
//   A_WIDTH   multiplicand width (>= 2)
//   B_WIDTH   multiplier width (>= 2); sets the number of row stages
//   ACC_WIDTH accumulator width (>= A_WIDTH+B_WIDTH)
//   SIGNED    0: unsigned operands, 1: two's-complement operands
//   SATURATE  1: clamp the accumulator on overflow, 0: wrap
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   in_valid  qualifies a, b and acc_clear
//   a, b      operands
//   acc_clear the qualified product starts a new accumulation
//   out_valid product/acc refer to an item emerging this cycle
//   product   exact product of the emerging item (held while idle)
//   acc       accumulator including the emerging product (held while idle)
//   overflow  sticky overflow since the last clear
module pipelined_mac_param #(
  parameter int unsigned A_WIDTH   = 3,
  parameter int unsigned B_WIDTH   = 3,
  parameter int unsigned ACC_WIDTH = 8,
  parameter bit          SIGNED    = 1'b0,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic                       acc_clear,
  output logic                       out_valid,
  output logic [A_WIDTH+B_WIDTH-1:0] product,
  output logic [ACC_WIDTH-1:0]       acc,
  output logic                       overflow
);

  localparam int unsigned PW = A_WIDTH + B_WIDTH;

  // Stage s (0..B_WIDTH) holds the sum of rows 0..s-1. The operands are
  // only needed by stages that still have a row to add.
  logic [B_WIDTH-1:0][A_WIDTH-1:0] op_a_q, op_a_d;
  logic [B_WIDTH-1:0][B_WIDTH-1:0] op_b_q, op_b_d;
  logic [B_WIDTH:0]                vld_q, vld_d;
  logic [B_WIDTH:0]                clr_q, clr_d;
  logic [B_WIDTH:0][PW-1:0]        sum_q, sum_d;

  // Finished-product register, which keeps the row adders and the
  // accumulator adder in separate cycles.
  logic          prod_vld_q, prod_vld_d;
  logic          prod_clr_q, prod_clr_d;
  logic [PW-1:0] prod_q, prod_d;

  logic                 out_valid_q, out_valid_d;
  logic [PW-1:0]        product_q, product_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 overflow_q, overflow_d;

  logic [PW-1:0]      a_ext;
  logic [PW-1:0]      row;
  logic [ACC_WIDTH:0] prod_ext;
  logic [ACC_WIDTH:0] acc_ext;
  logic [ACC_WIDTH:0] acc_sum;
  logic               acc_ovf;

  // Multiplier array: one partial-product row per stage.
  always_comb begin
    vld_d    = '0;
    clr_d    = '0;
    sum_d    = '0;
    op_a_d   = '0;
    op_b_d   = '0;
    a_ext    = '0;
    row      = '0;

    vld_d[0]  = in_valid;
    clr_d[0]  = in_valid & acc_clear;
    op_a_d[0] = a;
    op_b_d[0] = b;

    for (int unsigned s = 1; s < B_WIDTH; s++) begin
      op_a_d[s] = op_a_q[s-1];
      op_b_d[s] = op_b_q[s-1];
    end

    for (int unsigned s = 0; s < B_WIDTH; s++) begin
      a_ext = SIGNED ? {{B_WIDTH{op_a_q[s][A_WIDTH-1]}}, op_a_q[s]}
                     : {{B_WIDTH{1'b0}}, op_a_q[s]};
      row   = op_b_q[s][s] ? (a_ext << s) : '0;
      // The multiplier's MSB carries weight -2^(B_WIDTH-1) in two's complement,
      // so its row is subtracted; this also makes min*min come out exact.
      if (SIGNED && (s == B_WIDTH - 1)) begin
        sum_d[s+1] = sum_q[s] - row;
      end else begin
        sum_d[s+1] = sum_q[s] + row;
      end
      vld_d[s+1] = vld_q[s];
      clr_d[s+1] = clr_q[s];
    end
  end

  always_comb begin
    prod_vld_d = vld_q[B_WIDTH];
    prod_clr_d = clr_q[B_WIDTH];
    prod_d     = sum_q[B_WIDTH];
  end

  // Accumulator with optional saturation.
  always_comb begin
    prod_ext = SIGNED ? {{(ACC_WIDTH + 1 - PW){prod_q[PW-1]}}, prod_q}
                      : {{(ACC_WIDTH + 1 - PW){1'b0}}, prod_q};
    acc_ext  = SIGNED ? {acc_q[ACC_WIDTH-1], acc_q} : {1'b0, acc_q};
    acc_sum  = acc_ext + prod_ext;
    acc_ovf  = SIGNED ? ((acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH]) &&
                         (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                      : acc_sum[ACC_WIDTH];

    out_valid_d = prod_vld_q;
    product_d   = product_q;
    acc_d       = acc_q;
    overflow_d  = overflow_q;

    if (prod_vld_q) begin
      product_d = prod_q;
      if (prod_clr_q) begin
        acc_d      = prod_ext[ACC_WIDTH-1:0];
        overflow_d = 1'b0;
      end else if (acc_ovf) begin
        overflow_d = 1'b1;
        if (SATURATE) begin
          // Signed overflow can only happen with matching signs, so the
          // accumulator's sign gives the clamp direction.
          if (!SIGNED) begin
            acc_d = '1;
          end else if (acc_q[ACC_WIDTH-1]) begin
            acc_d = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
          end else begin
            acc_d = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
          end
        end else begin
          acc_d = acc_sum[ACC_WIDTH-1:0];
        end
      end else begin
        acc_d = acc_sum[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      vld_q       <= '0;
      clr_q       <= '0;
      sum_q       <= '0;
      prod_vld_q  <= 1'b0;
      prod_clr_q  <= 1'b0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      acc_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      vld_q       <= vld_d;
      clr_q       <= clr_d;
      sum_q       <= sum_d;
      prod_vld_q  <= prod_vld_d;
      prod_clr_q  <= prod_clr_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      acc_q       <= acc_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign acc       = acc_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_mac_param.sv
// Directed bench for pipelined_mac_param. Three instances share one
// stimulus bus: unsigned/saturating (defaults), unsigned/wrapping and
// signed/saturating. Each sequence starts with a clear so the instances
// can be checked independently.
module tb_pipelined_mac_param;

  localparam int unsigned Lat = 5;  // B_WIDTH + 2 at the defaults

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic [2:0] a;
  logic [2:0] b;
  logic       acc_clear;

  logic       ov0, ov1, ov2;
  logic [5:0] p0, p1, p2;
  logic [7:0] acc0, acc1, acc2;
  logic       of0, of1, of2;

  int n_checks = 0;
  int n_fail   = 0;

  // Sequence table: per item inputs and expected outputs.
  int         n;
  bit         sv[16];
  bit         sc[16];
  logic [2:0] sa[16];
  logic [2:0] sb[16];
  logic [5:0] ep[16];
  logic [7:0] ea[16];
  bit         eo[16];

  pipelined_mac_param u_dut_sat (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .acc_clear (acc_clear),
    .out_valid (ov0),
    .product   (p0),
    .acc       (acc0),
    .overflow  (of0)
  );

  pipelined_mac_param #(
    .SATURATE (1'b0)
  ) u_dut_wrap (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .acc_clear (acc_clear),
    .out_valid (ov1),
    .product   (p1),
    .acc       (acc1),
    .overflow  (of1)
  );

  pipelined_mac_param #(
    .SIGNED (1'b1)
  ) u_dut_sgn (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .acc_clear (acc_clear),
    .out_valid (ov2),
    .product   (p2),
    .acc       (acc2),
    .overflow  (of2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_item(input int i, input bit v, input bit c, input int aa, input int bb,
                          input int p, input int ac, input bit of);
    sv[i] = v;
    sc[i] = c;
    sa[i] = 3'(aa);
    sb[i] = 3'(bb);
    ep[i] = 6'(p);
    ea[i] = 8'(ac);
    eo[i] = of;
  endtask

  // Plays the table one item per edge, then checks every output slot of
  // the selected instance, including hold behaviour in idle slots.
  task automatic run_seq(input string tag, input int sel);
    logic       ov;
    logic [5:0] p;
    logic [7:0] ac;
    logic       of;
    logic [7:0] hold;
    bit         seen;
    int         k;
    hold = '0;
    seen = 1'b0;
    for (int j = 0; j < n + 7; j++) begin
      if (j < n) begin
        in_valid  = sv[j];
        acc_clear = sc[j];
        a         = sa[j];
        b         = sb[j];
      end else begin
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        a         = '0;
        b         = '0;
      end
      @(posedge clk);
      #1;
      case (sel)
        0:       begin ov = ov0; p = p0; ac = acc0; of = of0; end
        1:       begin ov = ov1; p = p1; ac = acc1; of = of1; end
        default: begin ov = ov2; p = p2; ac = acc2; of = of2; end
      endcase
      k = j - int'(Lat);
      if (k >= 0 && k < n && sv[k]) begin
        check_eq($sformatf("%s[%0d].out_valid", tag, j), 32'(ov), 32'd1);
        check_eq($sformatf("%s[%0d].product", tag, j), 32'(p), 32'(ep[k]));
        check_eq($sformatf("%s[%0d].acc", tag, j), 32'(ac), 32'(ea[k]));
        check_eq($sformatf("%s[%0d].overflow", tag, j), 32'(of), 32'(eo[k]));
        hold = ea[k];
        seen = 1'b1;
      end else begin
        check_eq($sformatf("%s[%0d].out_valid", tag, j), 32'(ov), 32'd0);
        if (seen) check_eq($sformatf("%s[%0d].acc_hold", tag, j), 32'(ac), 32'(hold));
      end
    end
  endtask

  initial begin
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    acc_clear = 1'b0;
    a         = '0;
    b         = '0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("reset.out_valid", 32'(ov0), 32'd0);
    check_eq("reset.product", 32'(p0), 32'd0);
    check_eq("reset.acc", 32'(acc0), 32'd0);
    check_eq("reset.overflow", 32'(of0), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Latency: single cleared item.
    n = 1;
    set_item(0, 1, 1, 5, 6, 30, 30, 0);
    run_seq("latency", 0);

    // Back-to-back stream with a clear at the head.
    n = 4;
    set_item(0, 1, 1, 7, 7, 49, 49, 0);
    set_item(1, 1, 0, 1, 2, 2, 51, 0);
    set_item(2, 1, 0, 3, 3, 9, 60, 0);
    set_item(3, 1, 0, 0, 5, 0, 60, 0);
    run_seq("b2b", 0);

    // Bubbles carry junk operands and acc_clear=1, which must be ignored.
    n = 5;
    set_item(0, 1, 1, 2, 3, 6, 6, 0);
    set_item(1, 0, 1, 7, 7, 0, 0, 0);
    set_item(2, 1, 0, 4, 4, 16, 22, 0);
    set_item(3, 0, 1, 5, 5, 0, 0, 0);
    set_item(4, 1, 1, 1, 1, 1, 1, 0);
    run_seq("bubble", 0);

    // Unsigned saturation, then the same stream on the wrapping instance.
    n = 6;
    set_item(0, 1, 1, 7, 7, 49, 49, 0);
    set_item(1, 1, 0, 7, 7, 49, 98, 0);
    set_item(2, 1, 0, 7, 7, 49, 147, 0);
    set_item(3, 1, 0, 7, 7, 49, 196, 0);
    set_item(4, 1, 0, 7, 7, 49, 245, 0);
    set_item(5, 1, 0, 7, 7, 49, 255, 1);
    run_seq("sat", 0);
    ea[5] = 8'd38;
    run_seq("wrap", 1);

    // Signed basics, including most-negative squared.
    n = 3;
    set_item(0, 1, 1, -4, -4, 16, 16, 0);
    set_item(1, 1, 0, 3, -4, -12, 4, 0);
    set_item(2, 1, 0, -1, 3, -3, 1, 0);
    run_seq("signed", 2);

    // Signed negative saturation: -12 per item clamps at -128 on the 11th,
    // then +16 moves it back inside range while overflow stays sticky.
    n = 12;
    for (int k = 0; k < 10; k++) set_item(k, 1, k == 0, -4, 3, -12, -12 * (k + 1), 0);
    set_item(10, 1, 0, -4, 3, -12, -128, 1);
    set_item(11, 1, 0, -4, -4, 16, -112, 1);
    run_seq("sneg", 2);

    // Reset mid-stream: three items in flight, half-cycle async reset pulse.
    for (int j = 0; j < 3; j++) begin
      in_valid  = 1'b1;
      acc_clear = 1'b0;
      a         = 3'(j + 3);
      b         = 3'd5;
      @(posedge clk);
      #1;
    end
    #2;
    in_valid  = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_eq("midrst.out_valid", 32'(ov0), 32'd0);
    check_eq("midrst.product", 32'(p0), 32'd0);
    check_eq("midrst.acc", 32'(acc0), 32'd0);
    check_eq("midrst.overflow_wrap", 32'(of1), 32'd0);
    check_eq("midrst.acc_sgn", 32'(acc2), 32'd0);
    check_eq("midrst.overflow_sgn", 32'(of2), 32'd0);
    #4 reset_n = 1'b1;
    for (int j = 0; j < int'(Lat) + 3; j++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("postrst[%0d].out_valid", j), 32'(ov0), 32'd0);
    end
    check_eq("postrst.acc", 32'(acc0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_mac_param.md
Name: pipelined_mac_param

Overview:
- Parametrised pipelined multiply-accumulate unit; next generation of the fixed 3x3 pipelined array-multiplier MAC.
- Adds: generic operand widths; signed or unsigned mode; a valid-tagged pipeline that accepts one operand pair per clock with bubbles allowed; an accumulator with in-band clear; and optional saturation with a sticky overflow flag.
- Sits between the operand block RAMs and the debug/ILA probe or downstream consumer.

Parameters:
- A_WIDTH, 3, multiplicand width in bits (>=2).
- B_WIDTH, 3, multiplier width in bits (>=2); one partial-product row is added per pipeline stage.
- ACC_WIDTH, 8, accumulator width; must be >= A_WIDTH+B_WIDTH.
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands (Baugh-Wooley or sign-extended rows).
- SATURATE, 1, 1 = clamp the accumulator on overflow, 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies a, b and acc_clear this cycle.
- a  input  A_WIDTH  multiplicand.
- b  input  B_WIDTH  multiplier.
- acc_clear  input  1  when sampled with in_valid=1, this product starts a new accumulation.
- out_valid  output  1  product and acc are valid this cycle.
- product  output  A_WIDTH+B_WIDTH  exact product of the pair emerging this cycle.
- acc  output  ACC_WIDTH  accumulator value including the emerging product.
- overflow  output  1  sticky; set when any accumulation since the last clear overflowed.

Behaviour:
- Reset: asserting reset_n low immediately clears all pipeline data, valid bits, acc, product, out_valid and overflow to 0, independent of clk. Release is synchronised by the integrator.
- Pipeline structure:
  - Stage 0 registers a, b, acc_clear and in_valid.
  - Stages 1..B_WIDTH each add one partial-product row (a AND b[i], shifted by i) to the running sum. Row i's b bit and the a operand travel alongside the data.
  - The final stage adds the product into the accumulator.
- Latency: a pair sampled at rising edge k appears with out_valid=1 after edge k+B_WIDTH+2, i.e. 5 edges at the defaults. Latency is fixed, with no dependence on data or bubbles.
- Throughput: one pair per clock; there is no backpressure and no ready signal.
- Bubbles: in_valid=0 inserts a bubble. A bubble never changes acc or overflow, and out_valid=0 in its output slot. product and acc hold their last valid values while out_valid=0.
- acc_clear is ignored when in_valid=0.
- Accumulate step when the emerging item is valid:
  - Clear-tagged item: acc <= extend(product); overflow <= 0.
  - Otherwise: sum = acc + extend(product), computed at ACC_WIDTH+1 bits. Extension is zero-extension when SIGNED=0 and sign-extension when SIGNED=1.
- Overflow detection:
  - Unsigned: carry out of bit ACC_WIDTH-1.
  - Signed: both operands share a sign and the result sign differs.
  - On overflow: SATURATE=1 clamps acc to 2^ACC_WIDTH-1 (unsigned), or to 2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1) (signed, by direction). SATURATE=0 keeps the wrapped sum. In both cases overflow is set to 1.
- Saturated accumulator: it stays clamped until a later product moves it back inside range (signed) or a clear arrives. overflow stays 1 until a clear-tagged item emerges.
- product is always exact; it never saturates because it fits in A_WIDTH+B_WIDTH bits.
- Signed corner case: the most-negative A times the most-negative B must give the exact positive product, e.g. -4 * -4 = 16 at the defaults.
- Reset mid-stream: all in-flight items are discarded and none emerge after reset is released.
- Simultaneity: a clear-tagged item directly following a non-clear item is handled back-to-back, with no lost or merged cycle.

Test Plan:
- Latency (defaults): in_valid=1, acc_clear=1, a=5, b=6 at edge 0 -> out_valid=1 only after edge 5, with product=30 and acc=30. out_valid=0 in every other cycle.
- Back-to-back stream: the pairs (7,7)c, (1,2), (3,3), (0,5) on consecutive edges -> four consecutive outputs with product 49, 2, 9, 0 and acc 49, 51, 60, 60.
- Bubbles and clear: (2,3)c, bubble, (4,4), bubble, (1,1)c -> outputs in slots 0, 2 and 4 only, with acc 6, 22, 1; acc holds 6 during slot 1.
- Saturation (defaults): (7,7)c followed by five more (7,7) -> acc 49, 98, 147, 196, 245, 255, with overflow=1 from the sixth output onward. Repeating with SATURATE=0 gives a sixth acc of 38 and overflow=1.
- Signed (SIGNED=1): (-4,-4)c, (3,-4), (-1,3) -> product 16, -12, -3 and acc 16, 4, 1. A negative saturation case reaches acc=-128 with overflow=1.
- Reset mid-operation: drive 3 valid items, then pulse reset_n low for half a cycle asynchronously -> all outputs are 0 immediately, and no out_valid pulse occurs for at least B_WIDTH+2 edges after release.
